// File: rtl/matrix_rd_arbiter_pkg.sv
// Shared widths, requester IDs and FSM types for the matrix BRAM read-port arbiter.
// The macros mirror matrix_pkg.vh so the block elaborates standalone.
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 16
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif
`ifndef RDARB_NUM_REQ
`define RDARB_NUM_REQ 3
`endif
`ifndef RDARB_ID_COMPUTE
`define RDARB_ID_COMPUTE 0
`endif
`ifndef RDARB_ID_DISPLAY
`define RDARB_ID_DISPLAY 1
`endif
`ifndef RDARB_ID_UART
`define RDARB_ID_UART 2
`endif

package matrix_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rdarb_state_e;

  localparam int RDARB_ID_W = 2;

  // Next requester index with wrap at n (n is at most 4).
  function automatic logic [1:0] next_idx(input logic [1:0] idx, input int n);
    logic [2:0] s;
    s = {1'b0, idx} + 3'd1;
    return (s >= 3'(n)) ? 2'd0 : s[1:0];
  endfunction

endpackage

// File: rtl/matrix_rd_arbiter_rr_pick.sv
// Round-robin pick: first requester at or after ptr, scanning upward with wrap.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] grant,
  output logic [1:0]   idx,
  output logic         any
);

  logic [2:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + 3'(i);
      if (cand >= 3'(N)) cand = cand - 3'(N);
      for (int j = 0; j < N; j++) begin
        if (!any && (cand == 3'(j)) && req[j]) begin
          any      = 1'b1;
          idx      = 2'(j);
          grant[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_rd_arbiter.sv
// Burst arbiter for the single matrix BRAM read port: one burst at a time,
// round-robin between requesters, responses steered back one-hot.
module matrix_rd_arbiter
  import matrix_rd_arbiter_pkg::*;
#(
  parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
  parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH,
  parameter int NUM_REQ       = `RDARB_NUM_REQ,
  parameter int RD_LATENCY    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]        req_len,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [ELEMENT_WIDTH-1:0]    rsp_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [NUM_REQ-1:0]          rsp_last,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0]    mem_rd_data,
  output logic                        busy,
  output logic [1:0]                  grant_id
);

  rdarb_state_e              state_q, state_d;
  logic [1:0]                rr_ptr_q, rr_ptr_d;
  logic [1:0]                grant_id_q, grant_id_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      rd_en_q, rd_en_d;
  logic                      busy_q, busy_d;
  logic [RD_LATENCY-1:0]     pipe_v_q, pipe_v_d;
  logic [RD_LATENCY-1:0]     pipe_last_q, pipe_last_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]        rsp_last_q, rsp_last_d;
  logic [ELEMENT_WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]        pick_grant;
  logic [1:0]                pick_idx;
  logic                      pick_any;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [7:0]                sel_len;
  logic [NUM_REQ-1:0]        grant_oh;
  logic                      rd_last;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    grant_oh = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      sel_addr    = sel_addr | (req_addr[j*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{pick_grant[j]}});
      sel_len     = sel_len  | (req_len[j*8 +: 8] & {8{pick_grant[j]}});
      grant_oh[j] = (grant_id_q == 2'(j));
    end
  end

  // Tags travel beside the BRAM read so they line up with mem_rd_data.
  assign rd_last = rd_en_q && (cnt_q == len_q - 8'd1);

  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_v_d[gi]    = rd_en_q;
      assign pipe_last_d[gi] = rd_last;
    end else begin : g_tail
      assign pipe_v_d[gi]    = pipe_v_q[gi-1];
      assign pipe_last_d[gi] = pipe_last_q[gi-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rd_en_d    = rd_en_q;
    req_ready  = '0;

    case (state_q)
      ST_IDLE: begin
        // Gated with rst so nothing is acknowledged while the block is held in reset.
        if (pick_any && !rst) begin
          req_ready  = pick_grant;
          grant_id_d = pick_idx;
          addr_d     = sel_addr;
          len_d      = sel_len;
          cnt_d      = '0;
          if (sel_len != 8'd0) begin
            state_d = ST_ISSUE;
            rd_en_d = 1'b1;
          end else begin
            rr_ptr_d = next_idx(pick_idx, NUM_REQ);
          end
        end
      end
      ST_ISSUE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q + 8'd1;
        if (rd_last) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (|rsp_last_q) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_idx(grant_id_q, NUM_REQ);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = pipe_v_q[RD_LATENCY-1] ? grant_oh : '0;
    rsp_last_d  = (pipe_v_q[RD_LATENCY-1] && pipe_last_q[RD_LATENCY-1]) ? grant_oh : '0;
    rsp_data_d  = pipe_v_q[RD_LATENCY-1] ? mem_rd_data : rsp_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      pipe_v_q    <= '0;
      pipe_last_q <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      pipe_v_q    <= pipe_v_d;
      pipe_last_q <= pipe_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: doc/matrix_rd_arbiter.md
# matrix_rd_arbiter

Round-robin burst arbiter sharing the single matrix BRAM read port between up to `NUM_REQ` requesters: compute engine, display/print path and UART dump. Each requester posts a burst (start address, element count). The arbiter grants one burst at a time, drives `mem_rd_en`/`mem_rd_addr`, and routes the returned elements back to the granted requester with valid/last flags. It sits between the mode controllers and the BRAM wrapper, replacing their direct `mem_rd_*` connections.

## Interface
- `ELEMENT_WIDTH`, default `` `ELEMENT_WIDTH ``: BRAM data width.
- `ADDR_WIDTH`, default `` `BRAM_ADDR_WIDTH ``: BRAM address width.
- `NUM_REQ`, default 3: number of requesters (2..4).
- `RD_LATENCY`, default 1: BRAM cycles from `mem_rd_en` to valid `mem_rd_data` (1..2).

Ports:
- `clk` in 1: system clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester burst request, held until accepted.
- `req_addr` in NUM_REQ*ADDR_WIDTH: burst start address, requester i in slice i.
- `req_len` in NUM_REQ*8: burst element count, requester i in slice i.
- `req_ready` out NUM_REQ: one-hot acceptance pulse.
- `rsp_data` out ELEMENT_WIDTH: returned element, shared by all requesters.
- `rsp_valid` out NUM_REQ: one-hot, marks `rsp_data` valid for requester i.
- `rsp_last` out NUM_REQ: one-hot, asserted with the final element of a burst.
- `mem_rd_en` out 1: BRAM read enable.
- `mem_rd_addr` out ADDR_WIDTH: BRAM read address.
- `mem_rd_data` in ELEMENT_WIDTH: BRAM read data.
- `busy` out 1: high whenever state is not IDLE.
- `grant_id` out 2: index of the current or last granted requester.

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE:**
  - If any `req_valid` is high, select the first requester at or after `rr_ptr`, scanning upward with modulo-NUM_REQ wrap.
  - Combinationally assert `req_ready[w]` for that requester. On the same edge, capture address, length and `grant_id`.
  - If len > 0, go to ISSUE.
  - If len == 0, consume the request with no reads and no responses, set `rr_ptr = w+1`, and stay in IDLE.
- **ISSUE:**
  - Assert `mem_rd_en` each cycle, with `mem_rd_addr` = captured address + k for k = 0..len-1.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
  - After the len-th read, go to DRAIN.
- **DRAIN:** wait until the final element has been returned, then set `rr_ptr = grant_id+1` mod NUM_REQ and go to IDLE.
- **Return path:**
  - A RD_LATENCY-deep shift register carries a valid bit and a last bit alongside the reads.
  - `rsp_valid[grant_id]` and `rsp_data` are registered from `mem_rd_data`.
  - `rsp_last` is set on element len-1.
- **Bus behaviour:**
  - Only one requester is served at a time; a burst is never pre-empted.
  - `req_valid` changes from other requesters during a burst are ignored until IDLE.
  - A requester may drop `req_valid` before it is accepted; nothing is recorded.
  - `rsp_valid`/`rsp_last` are one-hot or zero; never two bits set.
  - No backpressure on responses: a requester must sink one element per cycle.
- **Reset:**
  - All outputs are 0 and state is IDLE; `rr_ptr` = 0 and `grant_id` = 0.
  - In-flight reads and pipeline contents are discarded.
  - No `rsp_last` is produced for an aborted burst.

## Timing
- Request accepted in IDLE at cycle T (`req_ready` high during T).
- First `mem_rd_en` at T+1; last at T+len.
- Response for read k appears at T+1+k+RD_LATENCY+1, one extra cycle for the output register.
- `rsp_last` arrives at T+len+RD_LATENCY+1; state returns to IDLE at the following cycle.
- The earliest next acceptance is that IDLE cycle.
- Throughput: one element per cycle within a burst. Gap between bursts: RD_LATENCY+2 cycles.
- Single-requester repeat: with `req_valid[i]` held continuously, i is re-granted after each burst when no other requester is pending.

## Structure
- `matrix_pkg.vh` holds the existing `` `ELEMENT_WIDTH `` and `` `BRAM_ADDR_WIDTH ``.
- Add to `matrix_pkg.vh`:
  - `` `RDARB_NUM_REQ `` (3).
  - Requester IDs `` `RDARB_ID_COMPUTE `` (0), `` `RDARB_ID_DISPLAY `` (1), `` `RDARB_ID_UART `` (2).
- The priority pick is one sub-module, `rr_pick`: combinational, with inputs request vector and pointer, and outputs one-hot winner, index and any-flag.
- The FSM, address counter and return shift register stay in the top module.

## Test plan
- Single burst: requester 0, addr 0x10, len 4, RD_LATENCY 1. Expect `mem_rd_addr` 0x10..0x13 at T+1..T+4; `rsp_valid[0]` at T+3..T+6 carrying mem[0x10..0x13]; `rsp_last[0]` at T+6 only.
- Round-robin: all three requesters continuously valid with len 2 each. Expect grant order 0,1,2,0,1,2 and no response overlap.
- Zero length: requester 1 with len 0. Expect a `req_ready[1]` pulse, no `mem_rd_en`, no `rsp_valid`, and the next grant going to requester 2 when 1 and 2 are both pending.
- Address wrap: ADDR_WIDTH 8, addr 0xFE, len 4. Expect `mem_rd_addr` 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-burst: assert `rst` during ISSUE of a len-8 burst. Expect outputs 0 immediately, no `rsp_last`, and a fresh grant to requester 0 after release.
- RD_LATENCY 2: len 3. Expect `rsp_last` at T+6 and `busy` low at T+7.
